// File: rtl/storage_pkg.sv
// Shared constants for the storage Wishbone arbiter: region map, FSM states,
// bridge strobe encodings and the address-region decoder.
package storage_pkg;

  localparam logic [7:0] RW0_REGION_C = 8'h00;
  localparam logic [7:0] RW1_REGION_C = 8'h10;
  localparam logic [7:0] RO_REGION_C  = 8'h20;

  localparam logic [1:0] STB_NONE = 2'b00;
  localparam logic [1:0] STB_RW   = 2'b01;
  localparam logic [1:0] STB_RO   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_LOCAL = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // STB_NONE means the access is completed locally (unmapped or RO write)
  function automatic logic [1:0] decode_stb(input logic [7:0] region,
                                            input logic       we,
                                            input logic [7:0] rw0,
                                            input logic [7:0] rw1,
                                            input logic [7:0] ro);
    if ((region == rw0) || (region == rw1)) begin
      decode_stb = STB_RW;
    end else if ((region == ro) && !we) begin
      decode_stb = STB_RO;
    end else begin
      decode_stb = STB_NONE;
    end
  endfunction

endpackage

// File: rtl/storage_rr_arbiter.sv
// Two-request round-robin arbiter; remembers the last served master and
// prefers the other one on a tie.
module storage_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_idx_i,
  output logic [1:0] grant_o
);

  logic last_q;

  // Tie goes to the master that was not served last
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Last-grant register; resets to 1 so m0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= served_idx_i;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/storage_wb_arbiter.sv
// Two-master Wishbone arbiter and region decoder in front of the storage bridge.
// Optional watchdog: define STORAGE_ARB_TIMEOUT_EN.
module storage_wb_arbiter
  import storage_pkg::*;
#(
  parameter logic [7:0]  RW0_REGION     = RW0_REGION_C,
  parameter logic [7:0]  RW1_REGION     = RW1_REGION_C,
  parameter logic [7:0]  RO_REGION      = RO_REGION_C,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic [1:0]  s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [1:0]  s_ack_i,
  input  logic [31:0] s_rw_dat_i,
  input  logic [31:0] s_ro_dat_i,
  output logic        timeout_o
);

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        cyc_q;
  logic [1:0]  stb_q;
  logic [1:0]  ack_q;
  logic [31:0] dat_q;

  logic [1:0]  req_s;
  logic [1:0]  arb_grant_s;
  logic [1:0]  req_stb_s;
  logic        update_s;
  logic        sel_cyc_s;
  logic        sel_we_s;
  logic [3:0]  sel_sel_s;
  logic [31:0] sel_adr_s;
  logic [31:0] sel_dat_s;

  assign req_s = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  // Abort and normal completion both count as having served the granted master
  assign update_s = (state_q == ST_RESP) || ((state_q == ST_BUSY) && !sel_cyc_s);

  storage_rr_arbiter u_rr (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .req_i        (req_s),
    .update_i     (update_s),
    .served_idx_i (grant_q[1]),
    .grant_o      (arb_grant_s)
  );

  assign req_stb_s = arb_grant_s[1]
                   ? decode_stb(m1_adr_i[23:16], m1_we_i, RW0_REGION, RW1_REGION, RO_REGION)
                   : decode_stb(m0_adr_i[23:16], m0_we_i, RW0_REGION, RW1_REGION, RO_REGION);

  assign sel_cyc_s = grant_q[1] ? m1_cyc_i : m0_cyc_i;
  assign sel_we_s  = grant_q[1] ? m1_we_i  : m0_we_i;
  assign sel_sel_s = grant_q[1] ? m1_sel_i : m0_sel_i;
  assign sel_adr_s = grant_q[1] ? m1_adr_i : m0_adr_i;
  assign sel_dat_s = grant_q[1] ? m1_dat_i : m0_dat_i;

  assign s_cyc_o  = cyc_q;
  assign s_stb_o  = stb_q;
  assign s_we_o   = cyc_q & sel_we_s;
  assign s_sel_o  = cyc_q ? sel_sel_s : 4'h0;
  assign s_adr_o  = cyc_q ? sel_adr_s : 32'h0;
  assign s_dat_o  = cyc_q ? sel_dat_s : 32'h0;
  assign m0_ack_o = ack_q[0];
  assign m1_ack_o = ack_q[1];
  assign m0_dat_o = dat_q;
  assign m1_dat_o = dat_q;

`ifdef STORAGE_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^{TIMEOUT_DATA, TIMEOUT_CYCLES};
  assign timeout_o = 1'b0;
`endif

  // Transaction FSM with registered bridge strobes, master acks and read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      cyc_q   <= 1'b0;
      stb_q   <= STB_NONE;
      ack_q   <= 2'b00;
      dat_q   <= 32'h0;
`ifdef STORAGE_ARB_TIMEOUT_EN
      cnt_q     <= 16'h0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 2'b00;
          if (arb_grant_s != 2'b00) begin
            grant_q <= arb_grant_s;
            if (req_stb_s != STB_NONE) begin
              state_q <= ST_BUSY;
              cyc_q   <= 1'b1;
              stb_q   <= req_stb_s;
`ifdef STORAGE_ARB_TIMEOUT_EN
              cnt_q   <= 16'h0;
`endif
            end else begin
              state_q <= ST_LOCAL;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!sel_cyc_s) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= STB_NONE;
          end else if (s_ack_i != 2'b00) begin
            dat_q   <= sel_we_s ? 32'h0 : (s_ack_i[1] ? s_ro_dat_i : s_rw_dat_i);
            ack_q   <= grant_q;
            cyc_q   <= 1'b0;
            stb_q   <= STB_NONE;
            state_q <= ST_RESP;
`ifdef STORAGE_ARB_TIMEOUT_EN
          end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            dat_q     <= TIMEOUT_DATA;
            ack_q     <= grant_q;
            cyc_q     <= 1'b0;
            stb_q     <= STB_NONE;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 16'h1;
`else
          end else begin
            state_q <= ST_BUSY;
`endif
          end
        end
        ST_LOCAL: begin
          dat_q   <= 32'h0;
          ack_q   <= grant_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ack_q   <= 2'b00;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= STB_NONE;
          ack_q   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_storage_wb_arbiter.sv
// Directed, table-driven bench for storage_wb_arbiter with a small bridge model.
module tb_storage_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        m0_ack, m1_ack;
  logic [31:0] m0_dat, m1_dat;
  logic        s_cyc, s_we, timeout;
  logic [1:0]  s_stb, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic [31:0] rw_dat, ro_dat;

  int          ack_mode;   // 0 bridge model, 1 ack=11 while strobed, 2 never ack, 3 forced value
  logic [1:0]  force_ack;
  int          stb_age;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  storage_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_ack_o(m0_ack), .m0_dat_o(m0_dat),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_ack_o(m1_ack), .m1_dat_o(m1_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack),
    .s_rw_dat_i(rw_dat), .s_ro_dat_i(ro_dat), .timeout_o(timeout)
  );

  // Bridge model: write acks 1 cycle after strobe, read 2 cycles after
  always @(posedge clk) stb_age <= (s_stb != 2'b00) ? stb_age + 1 : 0;

  always_comb begin
    s_ack = 2'b00;
    case (ack_mode)
      0: if ((s_stb != 2'b00) && (stb_age == (s_we ? 1 : 2))) s_ack = s_stb;
      1: if (s_stb != 2'b00) s_ack = 2'b11;
      3: s_ack = force_ack;
      default: s_ack = 2'b00;
    endcase
  end

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rw;
    logic [31:0] ro;
    int          mode;
    logic [1:0]  stb;
    logic [31:0] dat;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 1) ? m1_ack : m0_ack;
  endfunction

  task automatic idle_masters();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_sel[i] = 4'h0; m_adr[i] = 32'h0; m_dat[i] = 32'h0;
    end
  endtask

  task automatic run_txn(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [1:0] exp_stb,
                         input logic [31:0] exp_dat, input int exp_lat);
    logic [31:0] got_dat;
    bit got = 1'b0;
    @(negedge clk);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_sel[m] = 4'hF; m_adr[m] = adr; m_dat[m] = wdat;
    for (int k = 1; (k <= 10) && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("stb_decode", {30'h0, s_stb}, {30'h0, exp_stb});
        if (exp_stb != 2'b00) begin
          chk("pass_adr", s_adr, adr);
          chk("pass_we", {31'h0, s_we}, {31'h0, we});
          chk("pass_dat", s_dat, wdat);
        end
      end
      chk("other_ack", {31'h0, ack_of(1 - m)}, 32'h0);
      if (ack_of(m)) begin
        got = 1'b1;
        got_dat = (m == 1) ? m1_dat : m0_dat;
        chk("ack_latency", k, exp_lat);
        chk("rd_data", got_dat, exp_dat);
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL ack_wait: no ack within 10 cycles, expected at %0d", exp_lat);
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    end
    @(negedge clk);
    chk("ack_pulse", {31'h0, ack_of(m)}, 32'h0);
  endtask

  initial begin
    int order[3];
    int nack;
    bit m0_seen;

    //        m we    adr            wdat           rw             ro             mode stb    dat            lat
    vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         32'h0,         0, 2'b01, 32'h0,         3};
    vecs[1] = '{1, 1'b0, 32'h0020_0004, 32'h0,         32'h0,         32'hCAFE_F00D, 0, 2'b10, 32'hCAFE_F00D, 4};
    vecs[2] = '{0, 1'b0, 32'h0010_0100, 32'h0,         32'hA5A5_0001, 32'h0,         0, 2'b01, 32'hA5A5_0001, 4};
    vecs[3] = '{0, 1'b0, 32'h0030_0000, 32'h0,         32'h7777_7777, 32'h8888_8888, 0, 2'b00, 32'h0,         2};
    vecs[4] = '{0, 1'b1, 32'h0020_0000, 32'h5555_AAAA, 32'h0,         32'h0,         0, 2'b00, 32'h0,         2};
    vecs[5] = '{1, 1'b1, 32'h0010_0008, 32'h0BAD_F00D, 32'h9999_9999, 32'h0,         0, 2'b01, 32'h0,         3};
    vecs[6] = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 32'h2222_2222, 1, 2'b01, 32'h2222_2222, 2};

    idle_masters();
    ack_mode = 0; force_ack = 2'b00; rw_dat = 32'h0; ro_dat = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_stb", {30'h0, s_stb}, 32'h0);
    chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
    chk("rst_dat", m0_dat, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);
    rst = 1'b0;

    // Round robin: both hold requests, expect m0, m1, m0
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'b1;
      m_sel[i] = 4'hF; m_adr[i] = 32'h0000_0100 + 32'(i); m_dat[i] = 32'h0;
    end
    nack = 0;
    for (int k = 0; (k < 40) && (nack < 3); k++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) chk("rr_dual_ack", 32'h1, 32'h0);
      if (m0_ack || m1_ack) begin
        order[nack] = m1_ack ? 1 : 0;
        nack++;
      end
    end
    idle_masters();
    chk("rr_count", nack, 3);
    if (nack == 3) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);
    end
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      rw_dat = vecs[v].rw; ro_dat = vecs[v].ro; ack_mode = vecs[v].mode;
      run_txn(vecs[v].m, vecs[v].we, vecs[v].adr, vecs[v].wdat,
              vecs[v].stb, vecs[v].dat, vecs[v].lat);
    end
    ack_mode = 0;

    // Abort: m0 drops cyc in its first BUSY cycle, late bridge ack, then m1 served
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
    m_adr[0] = 32'h0000_0020; m_dat[0] = 32'h1;
    @(negedge clk);
    chk("abort_busy_stb", {30'h0, s_stb}, 32'h1);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_sel[1] = 4'hF;
    m_adr[1] = 32'h0020_0004; ro_dat = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_idle_stb", {30'h0, s_stb}, 32'h0);
    ack_mode = 3; force_ack = 2'b01;
    @(negedge clk);
    ack_mode = 0; force_ack = 2'b00;
    m0_seen = 1'b0; nack = 0;
    for (int k = 0; (k < 12) && (nack == 0); k++) begin
      if (m0_ack) m0_seen = 1'b1;
      if (m1_ack) begin
        nack = 1;
        chk("abort_m1_dat", m1_dat, 32'hCAFE_F00D);
      end else begin
        @(negedge clk);
      end
    end
    chk("abort_no_m0_ack", {31'h0, m0_seen}, 32'h0);
    chk("abort_m1_served", nack, 1);
    idle_masters();
    repeat (2) @(negedge clk);

`ifdef STORAGE_ARB_TIMEOUT_EN
    ack_mode = 2;
    run_txn(0, 1'b1, 32'h0000_0040, 32'h4, 2'b01, 32'hDEAD_BEEF, 5);
    ack_mode = 0;
    chk("timeout_set", {31'h0, timeout}, 32'h1);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", {31'h0, timeout}, 32'h1);
`endif

    // Reset during BUSY: strobes drop, no ack follows
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_sel[0] = 4'hF;
    m_adr[0] = 32'h0000_0004;
    @(negedge clk);
    chk("midrst_busy_stb", {30'h0, s_stb}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stb", {30'h0, s_stb}, 32'h0);
    chk("midrst_cyc", {31'h0, s_cyc}, 32'h0);
    chk("midrst_timeout", {31'h0, timeout}, 32'h0);
    idle_masters();
    rst = 1'b0;
    m0_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m0_ack || m1_ack) m0_seen = 1'b1;
    end
    chk("midrst_no_ack", {31'h0, m0_seen}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
